v_ddr_rd_stream: RTL and testbench

- Read-side DDR streaming engine for the vector load path.
- Accepts a transfer command from the vector memory unit (ctrl_raddr_offset_o, ctrl_rxfer_size_o, ctrl_rstart_o), reads words from a synchronous-read DDR array port, and returns them as a valid/ready/last stream (rd_tdata_i, rd_tvalid_i, rd_tlast_i).
- Pulses ctrl_rdone_i once the final beat is accepted.
- Sits directly downstream of the vector load/store unit's read control port and feeds its read stream.

---
 rtl/v_ddr_rd_stream_if.sv | 42 ++++
 rtl/v_ddr_rd_stream.sv | 168 ++++++++++++++++
 tb/tb_v_ddr_rd_stream.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/v_ddr_rd_stream_if.sv
// Read-stream bundle for the vector load path: the transfer command, the
// returned valid/ready/last stream, and the synchronous DDR read port.
interface v_ddr_rd_stream_if #(
    parameter int DDR_DEPTH = 4096
);
    localparam int AW = $clog2(DDR_DEPTH);

    logic [31:0]   ctrl_raddr_offset;
    logic [31:0]   ctrl_rxfer_size;
    logic          ctrl_rstart;
    logic          ctrl_rdone;
    logic [31:0]   rd_tdata;
    logic          rd_tvalid;
    logic          rd_tready;
    logic          rd_tlast;
    logic          mem_en;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_rdata;
    logic          busy;

    // Streaming engine side
    modport slave (
        input  ctrl_raddr_offset, ctrl_rxfer_size, ctrl_rstart,
        output ctrl_rdone,
        output rd_tdata, rd_tvalid, rd_tlast,
        input  rd_tready,
        output mem_en, mem_addr,
        input  mem_rdata,
        output busy
    );

    // Command issuer / stream consumer / memory side
    modport master (
        output ctrl_raddr_offset, ctrl_rxfer_size, ctrl_rstart,
        input  ctrl_rdone,
        input  rd_tdata, rd_tvalid, rd_tlast,
        output rd_tready,
        input  mem_en, mem_addr,
        output mem_rdata,
        input  busy
    );
endinterface

// File: rtl/v_ddr_rd_stream.sv
// Read-side DDR streaming engine. Latches a byte offset / byte length
// command, issues word reads to a synchronous-read DDR port and returns
// the words through a small FIFO as a valid/ready/last stream.
module v_ddr_rd_stream #(
    parameter int DDR_DEPTH  = 4096,
    parameter int FIFO_DEPTH = 2
) (
    input logic              clk,
    input logic              rstn,
    v_ddr_rd_stream_if.slave bus
);
    localparam int AW = $clog2(DDR_DEPTH);
    localparam int FW = $clog2(FIFO_DEPTH);
    localparam int CW = FW + 1;
    localparam logic [CW:0] FIFO_LIMIT = (CW+1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state_q, state_d;

    // Latched command and progress counters
    logic [29:0]   beats_q;
    logic [29:0]   issued_q;
    logic [29:0]   sent_q;
    logic [AW-1:0] addr_q;
    logic          inflight_q;

    // Output FIFO
    logic [31:0]   fifo_mem [FIFO_DEPTH];
    logic [FW-1:0] wr_ptr_q;
    logic [FW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;

    // Decoded command fields and handshake terms
    logic [29:0]   cmd_beats;
    logic [AW-1:0] cmd_word;
    logic          start_accept;
    logic          valid;
    logic          pop;
    logic          last;
    logic [CW:0]   occ_next;
    logic          issue;
    logic          busy_int;
    logic          done_int;
    logic          unused_cmd_bits;

    assign cmd_beats    = bus.ctrl_rxfer_size[31:2];
    assign cmd_word     = bus.ctrl_raddr_offset[AW+1:2];
    assign start_accept = (state_q == IDLE) && bus.ctrl_rstart;

    assign unused_cmd_bits = ^{bus.ctrl_raddr_offset[31:AW+2],
                               bus.ctrl_raddr_offset[1:0],
                               bus.ctrl_rxfer_size[1:0]};

    assign valid = (count_q != '0);
    assign pop   = valid && bus.rd_tready;
    assign last  = valid && (sent_q == beats_q - 30'd1);

    // Words already in the FIFO plus the one still coming back from memory,
    // less the beat leaving this cycle, must leave room for a new read.
    assign occ_next = {1'b0, count_q} + (CW+1)'(inflight_q) - (CW+1)'(pop);

    // Next-state and per-state outputs
    always_comb begin
        state_d  = state_q;
        issue    = 1'b0;
        busy_int = 1'b0;
        done_int = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.ctrl_rstart) begin
                    state_d = (cmd_beats != '0) ? READ : DONE;
                end
            end
            READ: begin
                busy_int = 1'b1;
                issue    = (issued_q < beats_q) && (occ_next < FIFO_LIMIT);
                if (pop && last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                done_int = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Command latch, read address and issue/sent counters
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            beats_q  <= '0;
            issued_q <= '0;
            sent_q   <= '0;
            addr_q   <= '0;
        end else if (start_accept) begin
            beats_q  <= cmd_beats;
            issued_q <= '0;
            sent_q   <= '0;
            addr_q   <= cmd_word;
        end else begin
            if (issue) begin
                issued_q <= issued_q + 30'd1;
                addr_q   <= addr_q + AW'(1);
            end
            if (pop) begin
                sent_q <= sent_q + 30'd1;
            end
        end
    end

    // Marks a read whose data appears on mem_rdata this cycle
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            inflight_q <= 1'b0;
        end else begin
            inflight_q <= issue;
        end
    end

    // FIFO write side: capture returning memory data
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_mem[i] <= '0;
            end
            wr_ptr_q <= '0;
        end else if (inflight_q) begin
            fifo_mem[wr_ptr_q] <= bus.mem_rdata;
            wr_ptr_q           <= wr_ptr_q + FW'(1);
        end
    end

    // FIFO read side and occupancy
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + FW'(1);
            end
            count_q <= count_q + CW'(inflight_q) - CW'(pop);
        end
    end

    assign bus.mem_en     = issue;
    assign bus.mem_addr   = addr_q;
    assign bus.busy       = busy_int;
    assign bus.ctrl_rdone = done_int;
    assign bus.rd_tvalid  = valid;
    assign bus.rd_tdata   = fifo_mem[rd_ptr_q];
    assign bus.rd_tlast   = last;
endmodule

// File: tb/tb_v_ddr_rd_stream.sv
// Bench for v_ddr_rd_stream: two instances (4096-word DDR / 2-entry FIFO and
// 16-word DDR / 4-entry FIFO) driven with the same directed commands and
// checked every cycle against a transfer-level model.
module tb_v_ddr_rd_stream;
    logic        clk = 1'b0;
    logic        rstn;
    logic [31:0] offset;
    logic [31:0] size;
    logic        rstart;
    logic        tready;

    int checks   = 0;
    int failures = 0;
    int timeouts = 0;
    int timeouts_seen = 0;

    // Literal expectations supplied per test
    logic [31:0] lit_data [2][8];
    int          lit_len   = 0;
    bit          lit_timing = 1'b0;
    int          lit_first = 0;
    int          lit_done  = 0;

    // Model state per instance
    int unsigned depth [2] = '{4096, 16};
    int unsigned fdep  [2] = '{2, 4};
    int unsigned m_n      [2];
    int unsigned m_start  [2];
    int unsigned m_issued [2];
    int unsigned m_popped [2];
    bit          m_active [2];
    bit          m_done_due [2];
    bit          m_prev_issue [2];
    bit          m_seen_valid [2];
    bit          m_stall [2];
    logic [31:0] m_stall_data [2];
    int          m_idx [2];

    logic [31:0] ddr_a [4096];
    logic [31:0] ddr_b [16];

    always #5 clk = ~clk;

    v_ddr_rd_stream_if #(.DDR_DEPTH(4096)) bus_a ();
    v_ddr_rd_stream_if #(.DDR_DEPTH(16))   bus_b ();

    assign bus_a.ctrl_raddr_offset = offset;
    assign bus_a.ctrl_rxfer_size   = size;
    assign bus_a.ctrl_rstart       = rstart;
    assign bus_a.rd_tready         = tready;
    assign bus_b.ctrl_raddr_offset = offset;
    assign bus_b.ctrl_rxfer_size   = size;
    assign bus_b.ctrl_rstart       = rstart;
    assign bus_b.rd_tready         = tready;

    v_ddr_rd_stream #(.DDR_DEPTH(4096), .FIFO_DEPTH(2)) dut_a (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus_a.slave)
    );

    v_ddr_rd_stream #(.DDR_DEPTH(16), .FIFO_DEPTH(4)) dut_b (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus_b.slave)
    );

    // Synchronous-read DDR arrays
    always @(posedge clk) begin
        if (bus_a.mem_en) bus_a.mem_rdata <= ddr_a[bus_a.mem_addr];
        if (bus_b.mem_en) bus_b.mem_rdata <= ddr_b[bus_b.mem_addr];
    end

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s dut%0d: got 0x%0h, expected 0x%0h @%0t", name, d, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the transfer model
    always @(negedge clk) begin : cmp
        logic [31:0] a_data [2];
        logic [31:0] a_addr [2];
        logic        a_valid [2];
        logic        a_last [2];
        logic        a_rdone [2];
        logic        a_men [2];
        logic        a_busy [2];
        bit          exp_valid, exp_issue, pop_now, done_next, idle_now;
        int unsigned occ, fifo_n;

        a_data[0] = bus_a.rd_tdata;  a_data[1] = bus_b.rd_tdata;
        a_addr[0] = 32'(bus_a.mem_addr); a_addr[1] = 32'(bus_b.mem_addr);
        a_valid[0] = bus_a.rd_tvalid; a_valid[1] = bus_b.rd_tvalid;
        a_last[0] = bus_a.rd_tlast;  a_last[1] = bus_b.rd_tlast;
        a_rdone[0] = bus_a.ctrl_rdone; a_rdone[1] = bus_b.ctrl_rdone;
        a_men[0] = bus_a.mem_en;     a_men[1] = bus_b.mem_en;
        a_busy[0] = bus_a.busy;      a_busy[1] = bus_b.busy;

        if (timeouts != timeouts_seen) begin
            checks++;
            failures++;
            $display("FAIL timeout: transfer did not complete within its cycle budget (count %0d)", timeouts);
            timeouts_seen = timeouts;
        end

        for (int d = 0; d < 2; d++) begin
            m_idx[d]++;
            if (!rstn) begin
                chk("rst_tvalid", d, 32'(a_valid[d]), 32'd0);
                chk("rst_tlast",  d, 32'(a_last[d]),  32'd0);
                chk("rst_rdone",  d, 32'(a_rdone[d]), 32'd0);
                chk("rst_mem_en", d, 32'(a_men[d]),   32'd0);
                chk("rst_busy",   d, 32'(a_busy[d]),  32'd0);
                chk("rst_addr",   d, a_addr[d],       32'd0);
                chk("rst_tdata",  d, a_data[d],       32'd0);
                m_active[d] = 0; m_done_due[d] = 0; m_prev_issue[d] = 0;
                m_issued[d] = 0; m_popped[d] = 0; m_stall[d] = 0; m_seen_valid[d] = 0;
            end else begin
                idle_now  = !m_active[d] && !m_done_due[d];
                occ       = m_issued[d] - m_popped[d];
                fifo_n    = occ - 32'(m_prev_issue[d]);
                exp_valid = m_active[d] && (fifo_n > 0);
                pop_now   = exp_valid && tready;
                exp_issue = m_active[d] && (m_issued[d] < m_n[d]) &&
                            ((occ - 32'(pop_now)) < fdep[d]);

                chk("tvalid", d, 32'(a_valid[d]), 32'(exp_valid));
                chk("busy",   d, 32'(a_busy[d]),  32'(m_active[d]));
                chk("rdone",  d, 32'(a_rdone[d]), 32'(m_done_due[d]));
                chk("mem_en", d, 32'(a_men[d]),   32'(exp_issue));
                if (exp_issue)
                    chk("mem_addr", d, a_addr[d], (m_start[d] + m_issued[d]) % depth[d]);
                if (exp_valid) begin
                    chk("tdata", d, a_data[d], ((m_start[d] + m_popped[d]) % depth[d]) + 32'h100);
                    chk("tlast", d, 32'(a_last[d]), 32'(m_popped[d] == m_n[d] - 1));
                    if (m_popped[d] < 32'(lit_len))
                        chk("lit_tdata", d, a_data[d], lit_data[d][m_popped[d]]);
                end else begin
                    chk("tlast_idle", d, 32'(a_last[d]), 32'd0);
                end
                if (m_stall[d]) begin
                    chk("stall_valid", d, 32'(a_valid[d]), 32'd1);
                    chk("stall_data",  d, a_data[d], m_stall_data[d]);
                end
                if (lit_timing && a_valid[d] && !m_seen_valid[d])
                    chk("lit_first_valid_cycle", d, 32'(m_idx[d]), 32'(lit_first));
                if (lit_timing && a_rdone[d])
                    chk("lit_done_cycle", d, 32'(m_idx[d]), 32'(lit_done));
                if (a_valid[d]) m_seen_valid[d] = 1;
                m_stall[d]      = a_valid[d] && !tready;
                m_stall_data[d] = a_data[d];

                done_next = 0;
                if (pop_now) begin
                    m_popped[d]++;
                    if (m_popped[d] == m_n[d]) begin
                        m_active[d] = 0;
                        done_next   = 1;
                    end
                end
                m_prev_issue[d] = exp_issue;
                if (exp_issue) m_issued[d]++;
                if (rstart && idle_now) begin
                    m_n[d]          = 32'(size[31:2]);
                    m_start[d]      = 32'(offset[31:2]) % depth[d];
                    m_issued[d]     = 0;
                    m_popped[d]     = 0;
                    m_prev_issue[d] = 0;
                    m_seen_valid[d] = 0;
                    m_idx[d]        = -1;
                    if (m_n[d] > 0) m_active[d] = 1;
                    else            done_next   = 1;
                end
                m_done_due[d] = done_next;
            end
        end
    end

    task automatic start(input logic [31:0] o, input logic [31:0] s);
        offset = o;
        size   = s;
        rstart = 1'b1;
        tready = 1'b1;
        @(posedge clk);
        #1 rstart = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input bit stall);
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        bit done = 0;
        for (int i = 0; i < budget && !done; i++) begin
            @(posedge clk);
            #1 tready = stall ? pat[i % 4] : 1'b1;
            done = !m_active[0] && !m_done_due[0] && !m_active[1] && !m_done_due[1];
        end
        if (!done) timeouts++;
        tready = 1'b1;
    endtask

    task automatic set_lit(input int n, input logic [31:0] base_a, input logic [31:0] base_b,
                           input int wrap_b);
        lit_len = n;
        for (int k = 0; k < n; k++) begin
            lit_data[0][k] = base_a + 32'(k);
            lit_data[1][k] = (k < wrap_b) ? base_b + 32'(k) : 32'h100 + 32'(k - wrap_b);
        end
    endtask

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Directed stimulus
    initial begin
        for (int k = 0; k < 4096; k++) ddr_a[k] = 32'h100 + 32'(k);
        for (int k = 0; k < 16; k++)   ddr_b[k] = 32'h100 + 32'(k);
        rstn = 1'b1; rstart = 1'b0; tready = 1'b1; offset = '0; size = '0;
        #1 rstn = 1'b0;
        repeat (3) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk);
        #1;

        // Four beats from word 4, consumer always ready
        set_lit(4, 32'h104, 32'h104, 8);
        lit_timing = 1; lit_first = 2; lit_done = 6;
        start(32'h10, 32'd16);
        wait_idle(40, 0);

        // Same transfer with consumer stalls
        lit_timing = 0;
        start(32'h10, 32'd16);
        wait_idle(60, 1);

        // Start at word 14: the 16-word array wraps to word 0
        set_lit(4, 32'h10E, 32'h10E, 2);
        start(32'h38, 32'd16);
        wait_idle(40, 1);

        // Zero-length transfers
        set_lit(0, 32'h0, 32'h0, 0);
        lit_timing = 1; lit_done = 0;
        start(32'h10, 32'd0);
        wait_idle(10, 0);
        start(32'h10, 32'd3);
        wait_idle(10, 0);
        lit_timing = 0;

        // A second start mid-transfer is ignored
        set_lit(8, 32'h110, 32'h100, 8);
        start(32'h40, 32'd32);
        repeat (3) @(posedge clk);
        #1 offset = 32'h200; size = 32'd8; rstart = 1'b1;
        @(posedge clk);
        #1 rstart = 1'b0;
        wait_idle(60, 0);

        // Reset after two beats, then a fresh transfer from word 9
        set_lit(0, 32'h0, 32'h0, 0);
        start(32'h80, 32'd32);
        begin
            bit reached = 0;
            for (int i = 0; i < 40 && !reached; i++) begin
                reached = (m_popped[0] >= 2);
                if (!reached) begin
                    @(posedge clk);
                    #1;
                end
            end
            if (!reached) timeouts++;
        end
        rstn = 1'b0;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        @(posedge clk);
        #1;
        set_lit(3, 32'h109, 32'h109, 8);
        lit_timing = 1; lit_first = 2; lit_done = 5;
        start(32'h24, 32'd12);
        wait_idle(40, 0);
        lit_timing = 0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
